// File: rtl/depar_merge_segs_pkg.sv
// -----------------------------------------------------------------------------
// depar_merge_segs_pkg
//   Shared deparser definitions: merge FSM state encoding, default datapath
//   widths and the segment beat record carried between the split and merge
//   blocks.
// -----------------------------------------------------------------------------
package depar_merge_segs_pkg;

  localparam int unsigned DEF_DW = 512;
  localparam int unsigned DEF_UW = 128;

  typedef enum logic [1:0] {
    SEND_FST  = 2'd0,
    SEND_SND  = 2'd1,
    FLUSH_SEG = 2'd2
  } depar_state_e;

  typedef struct packed {
    logic [DEF_DW-1:0]   tdata;
    logic [DEF_UW-1:0]   tuser;
    logic [DEF_DW/8-1:0] tkeep;
    logic                tlast;
  } seg_beat_t;

endpackage

// File: rtl/depar_axis_out_reg.sv
// -----------------------------------------------------------------------------
// depar_axis_out_reg
//   Single-entry registered AXI-Stream master stage.
//   Ports:
//     clk, aresetn      clock, asynchronous active-low reset
//     load_i            capture the *_i beat this cycle (only when can_load_o)
//     tdata/tuser/tkeep/tlast_i  beat to capture
//     can_load_o        register empty or being drained this cycle
//     m_*_o             registered AXIS outputs
//     m_tready_i        downstream ready
// -----------------------------------------------------------------------------
module depar_axis_out_reg #(
  parameter int unsigned DW = 512,
  parameter int unsigned UW = 128
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            load_i,
  input  logic [DW-1:0]   tdata_i,
  input  logic [UW-1:0]   tuser_i,
  input  logic [DW/8-1:0] tkeep_i,
  input  logic            tlast_i,
  output logic            can_load_o,
  output logic [DW-1:0]   m_tdata_o,
  output logic [UW-1:0]   m_tuser_o,
  output logic [DW/8-1:0] m_tkeep_o,
  output logic            m_tlast_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i
);

  logic [DW-1:0]   tdata_q;
  logic [UW-1:0]   tuser_q;
  logic [DW/8-1:0] tkeep_q;
  logic            tlast_q;
  logic            tvalid_q;

  assign can_load_o = !tvalid_q || m_tready_i;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tuser_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (load_i) begin
      tdata_q  <= tdata_i;
      tuser_q  <= tuser_i;
      tkeep_q  <= tkeep_i;
      tlast_q  <= tlast_i;
      tvalid_q <= 1'b1;
    end else if (m_tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_tdata_o  = tdata_q;
  assign m_tuser_o  = tuser_q;
  assign m_tkeep_o  = tkeep_q;
  assign m_tlast_o  = tlast_q;
  assign m_tvalid_o = tvalid_q;

endmodule

// File: rtl/depar_merge_segs.sv
// -----------------------------------------------------------------------------
// depar_merge_segs
//   Deparser back end: reassembles one AXI-Stream packet from three FWFT FIFOs
//   (first-half: segment 0; second-half: segment 1 or a dummy for single-
//   segment packets; remaining-segment: segments 2..N) and drives a registered
//   AXIS master with full tready backpressure.
//   Ports:
//     clk, aresetn                 clock, asynchronous active-low reset
//     fst_half_fifo_*              first-half FIFO head / empty / pop
//     snd_half_fifo_*              second-half FIFO head / empty / pop
//     seg_fifo_*                   remaining-segment FIFO head / empty / pop
//     m_axis_*                     registered output stream
//     pkt_cnt                      packets whose tlast beat was accepted
// -----------------------------------------------------------------------------
module depar_merge_segs
  import depar_merge_segs_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                             clk,
  input  logic                             aresetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]     fst_half_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    fst_half_fifo_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   fst_half_fifo_tkeep,
  input  logic                             fst_half_fifo_tlast,
  input  logic                             fst_half_fifo_empty,
  output logic                             fst_half_fifo_rd_en,

  input  logic [C_AXIS_DATA_WIDTH-1:0]     snd_half_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    snd_half_fifo_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   snd_half_fifo_tkeep,
  input  logic                             snd_half_fifo_tlast,
  input  logic                             snd_half_fifo_empty,
  output logic                             snd_half_fifo_rd_en,

  input  logic [C_AXIS_DATA_WIDTH-1:0]     seg_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    seg_fifo_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   seg_fifo_tkeep,
  input  logic                             seg_fifo_tlast,
  input  logic                             seg_fifo_empty,
  output logic                             seg_fifo_rd_en,

  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,

  output logic [31:0]                      pkt_cnt
);

  localparam int unsigned DW = C_AXIS_DATA_WIDTH;
  localparam int unsigned UW = C_AXIS_TUSER_WIDTH;

  depar_state_e state_q, state_d;
  logic         can_load;
  logic         fst_rd, snd_rd, seg_rd;
  logic         load;
  logic [31:0]  pkt_cnt_q;

  logic [DW-1:0]   ld_tdata;
  logic [UW-1:0]   ld_tuser;
  logic [DW/8-1:0] ld_tkeep;
  logic            ld_tlast;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= SEND_FST;
    else          state_q <= state_d;
  end

  // Pops are gated by aresetn so no FIFO is drained while reset is held.
  always_comb begin
    state_d = state_q;
    fst_rd  = 1'b0;
    snd_rd  = 1'b0;
    seg_rd  = 1'b0;
    if (aresetn && can_load) begin
      unique case (state_q)
        SEND_FST: begin
          if (!fst_half_fifo_empty) begin
            if (fst_half_fifo_tlast) begin
              // Single-segment packet: the second-half FIFO holds a dummy
              // entry that must be discarded alongside segment 0.
              if (!snd_half_fifo_empty) begin
                fst_rd = 1'b1;
                snd_rd = 1'b1;
              end
            end else begin
              fst_rd  = 1'b1;
              state_d = SEND_SND;
            end
          end
        end
        SEND_SND: begin
          if (!snd_half_fifo_empty) begin
            snd_rd  = 1'b1;
            state_d = snd_half_fifo_tlast ? SEND_FST : FLUSH_SEG;
          end
        end
        FLUSH_SEG: begin
          if (!seg_fifo_empty) begin
            seg_rd = 1'b1;
            if (seg_fifo_tlast) state_d = SEND_FST;
          end
        end
        default: state_d = SEND_FST;
      endcase
    end
  end

  assign load = fst_rd | snd_rd | seg_rd;

  // The first-half entry wins when both halves pop (the snd one is the dummy).
  always_comb begin
    ld_tdata = fst_half_fifo_tdata;
    ld_tuser = fst_half_fifo_tuser;
    ld_tkeep = fst_half_fifo_tkeep;
    ld_tlast = fst_half_fifo_tlast;
    if (seg_rd) begin
      ld_tdata = seg_fifo_tdata;
      ld_tuser = seg_fifo_tuser;
      ld_tkeep = seg_fifo_tkeep;
      ld_tlast = seg_fifo_tlast;
    end else if (snd_rd && !fst_rd) begin
      ld_tdata = snd_half_fifo_tdata;
      ld_tuser = snd_half_fifo_tuser;
      ld_tkeep = snd_half_fifo_tkeep;
      ld_tlast = snd_half_fifo_tlast;
    end
  end

  depar_axis_out_reg #(
    .DW (DW),
    .UW (UW)
  ) u_out_reg (
    .clk        (clk),
    .aresetn    (aresetn),
    .load_i     (load),
    .tdata_i    (ld_tdata),
    .tuser_i    (ld_tuser),
    .tkeep_i    (ld_tkeep),
    .tlast_i    (ld_tlast),
    .can_load_o (can_load),
    .m_tdata_o  (m_axis_tdata),
    .m_tuser_o  (m_axis_tuser),
    .m_tkeep_o  (m_axis_tkeep),
    .m_tlast_o  (m_axis_tlast),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign fst_half_fifo_rd_en = fst_rd;
  assign snd_half_fifo_rd_en = snd_rd;
  assign seg_fifo_rd_en      = seg_rd;
  assign pkt_cnt             = pkt_cnt_q;

endmodule

// File: tb/tb_depar_merge_segs.sv
module tb_depar_merge_segs;
  import depar_merge_segs_pkg::*;

  localparam int unsigned DW = 512;
  localparam int unsigned UW = 128;
  localparam int unsigned KW = DW / 8;
  typedef logic [DW-1:0] wv_t;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [DW-1:0] fst_tdata, snd_tdata, seg_tdata, m_tdata;
  logic [UW-1:0] fst_tuser, snd_tuser, seg_tuser, m_tuser;
  logic [KW-1:0] fst_tkeep, snd_tkeep, seg_tkeep, m_tkeep;
  logic fst_tlast, snd_tlast, seg_tlast, m_tlast;
  logic fst_empty, snd_empty, seg_empty;
  logic fst_rd, snd_rd, seg_rd;
  logic m_tvalid, m_tready;
  logic [31:0] pkt_cnt;

  depar_merge_segs #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW)
  ) dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .fst_half_fifo_tdata (fst_tdata),
    .fst_half_fifo_tuser (fst_tuser),
    .fst_half_fifo_tkeep (fst_tkeep),
    .fst_half_fifo_tlast (fst_tlast),
    .fst_half_fifo_empty (fst_empty),
    .fst_half_fifo_rd_en (fst_rd),
    .snd_half_fifo_tdata (snd_tdata),
    .snd_half_fifo_tuser (snd_tuser),
    .snd_half_fifo_tkeep (snd_tkeep),
    .snd_half_fifo_tlast (snd_tlast),
    .snd_half_fifo_empty (snd_empty),
    .snd_half_fifo_rd_en (snd_rd),
    .seg_fifo_tdata      (seg_tdata),
    .seg_fifo_tuser      (seg_tuser),
    .seg_fifo_tkeep      (seg_tkeep),
    .seg_fifo_tlast      (seg_tlast),
    .seg_fifo_empty      (seg_empty),
    .seg_fifo_rd_en      (seg_rd),
    .m_axis_tdata        (m_tdata),
    .m_axis_tuser        (m_tuser),
    .m_axis_tkeep        (m_tkeep),
    .m_axis_tlast        (m_tlast),
    .m_axis_tvalid       (m_tvalid),
    .m_axis_tready       (m_tready),
    .pkt_cnt             (pkt_cnt)
  );

  // Reference model: three FIFO contents plus the expected output stream.
  seg_beat_t fq[$], sq[$], gq[$], expq[$];
  int unsigned acc_pkts;
  int unsigned passed = 0;
  int unsigned total  = 0;
  bit starve_f, starve_s, starve_g;
  bit pop_f, pop_s, pop_g;
  bit prev_stall;
  seg_beat_t prev_out;

  task automatic chk(input string tag, input wv_t got, input wv_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic seg_beat_t rnd_beat(input bit last);
    seg_beat_t b;
    for (int i = 0; i < 16; i++) b.tdata[i*32 +: 32] = $urandom;
    b.tuser = {$urandom, $urandom, $urandom, $urandom};
    b.tkeep = {$urandom, $urandom};
    b.tlast = last;
    return b;
  endfunction

  // A packet of nseg segments, split into the three FIFOs as upstream would.
  task automatic add_pkt(input int unsigned nseg);
    seg_beat_t b;
    b = rnd_beat(nseg == 1);
    fq.push_back(b);
    expq.push_back(b);
    if (nseg == 1) begin
      sq.push_back('0);
    end else begin
      b = rnd_beat(nseg == 2);
      sq.push_back(b);
      expq.push_back(b);
      for (int s = 2; s < int'(nseg); s++) begin
        b = rnd_beat(s == int'(nseg) - 1);
        gq.push_back(b);
        expq.push_back(b);
      end
    end
  endtask

  task automatic drive_heads();
    seg_beat_t h;
    h = (fq.size() != 0) ? fq[0] : '0;
    fst_tdata = h.tdata; fst_tuser = h.tuser; fst_tkeep = h.tkeep; fst_tlast = h.tlast;
    fst_empty = starve_f || (fq.size() == 0);
    h = (sq.size() != 0) ? sq[0] : '0;
    snd_tdata = h.tdata; snd_tuser = h.tuser; snd_tkeep = h.tkeep; snd_tlast = h.tlast;
    snd_empty = starve_s || (sq.size() == 0);
    h = (gq.size() != 0) ? gq[0] : '0;
    seg_tdata = h.tdata; seg_tuser = h.tuser; seg_tkeep = h.tkeep; seg_tlast = h.tlast;
    seg_empty = starve_g || (gq.size() == 0);
  endtask

  task automatic model_reset();
    fq.delete(); sq.delete(); gq.delete(); expq.delete();
    acc_pkts = 0;
    pop_f = 0; pop_s = 0; pop_g = 0;
    prev_stall = 0;
  endtask

  // Called away from the clock edge: rules checks plus the output scoreboard.
  task automatic observe();
    seg_beat_t e;
    chk("rd_en_while_stalled", wv_t'((m_tvalid && !m_tready) && (fst_rd || snd_rd || seg_rd)), '0);
    chk("rd_on_empty", wv_t'((fst_rd && fst_empty) || (snd_rd && snd_empty) || (seg_rd && seg_empty)), '0);
    chk("multi_rd", wv_t'((fst_rd && snd_rd && !fst_tlast) || (seg_rd && (fst_rd || snd_rd))), '0);
    chk("pkt_cnt", wv_t'(pkt_cnt), wv_t'(acc_pkts));
    if (prev_stall) begin
      chk("hold_tvalid", wv_t'(m_tvalid), wv_t'(1));
      chk("hold_tdata", m_tdata, prev_out.tdata);
      chk("hold_tlast", wv_t'(m_tlast), wv_t'(prev_out.tlast));
    end
    if (m_tvalid && m_tready) begin
      if (expq.size() == 0) begin
        chk("extra_beat", wv_t'(1), '0);
      end else begin
        e = expq.pop_front();
        chk("beat_tdata", m_tdata, e.tdata);
        chk("beat_tuser", wv_t'(m_tuser), wv_t'(e.tuser));
        chk("beat_tkeep", wv_t'(m_tkeep), wv_t'(e.tkeep));
        chk("beat_tlast", wv_t'(m_tlast), wv_t'(e.tlast));
        if (e.tlast) acc_pkts++;
      end
    end
    prev_stall     = m_tvalid && !m_tready;
    prev_out.tdata = m_tdata;
    prev_out.tuser = m_tuser;
    prev_out.tkeep = m_tkeep;
    prev_out.tlast = m_tlast;
    pop_f = fst_rd; pop_s = snd_rd; pop_g = seg_rd;
  endtask

  task automatic step(input bit sf, input bit ss, input bit sg, input bit tr);
    @(posedge clk);
    #1;
    if (pop_f && fq.size() != 0) void'(fq.pop_front());
    if (pop_s && sq.size() != 0) void'(sq.pop_front());
    if (pop_g && gq.size() != 0) void'(gq.pop_front());
    pop_f = 0; pop_s = 0; pop_g = 0;
    starve_f = sf; starve_s = ss; starve_g = sg;
    m_tready = tr;
    drive_heads();
    @(negedge clk);
    observe();
  endtask

  task automatic release_reset();
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    observe();
  endtask

  initial begin
    logic [5:0] vec;
    int unsigned base;

    aresetn = 1'b0;
    m_tready = 1'b1;
    starve_f = 0; starve_s = 0; starve_g = 0;
    model_reset();

    // Reset state with a 1-segment packet already waiting.
    add_pkt(1);
    drive_heads();
    @(negedge clk);
    chk("rst_tvalid", wv_t'(m_tvalid), '0);
    chk("rst_tdata", m_tdata, '0);
    chk("rst_pkt_cnt", wv_t'(pkt_cnt), '0);
    chk("rst_rd_en", wv_t'({fst_rd, snd_rd, seg_rd}), '0);

    // 1-segment packet: both halves popped together.
    release_reset();
    chk("1seg_both_rd", wv_t'({fst_rd, snd_rd, seg_rd}), wv_t'(3'b110));
    step(0, 0, 0, 1);
    chk("1seg_latency", wv_t'(m_tvalid), wv_t'(1));
    step(0, 0, 0, 1);
    chk("1seg_pkt_cnt", wv_t'(pkt_cnt), wv_t'(1));

    // 4-segment packet on consecutive cycles.
    add_pkt(4);
    vec = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      vec[5-i] = m_tvalid;
    end
    chk("4seg_tvalid_run", wv_t'(vec), wv_t'(6'b011110));

    // Backpressure: 3-segment packet, tready 1,0,0,1,...
    add_pkt(3);
    for (int i = 0; i < 14; i++) step(0, 0, 0, (i % 4 == 0) || (i % 4 == 3));
    step(0, 0, 0, 1);
    chk("bp_all_delivered", wv_t'(expq.size()), '0);

    // Starvation of the second-half FIFO after segment 0.
    add_pkt(2);
    step(0, 0, 0, 1);
    chk("starve_fst_rd", wv_t'({fst_rd, snd_rd, seg_rd}), wv_t'(3'b100));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1);
      chk("starve_no_rd", wv_t'({fst_rd, snd_rd, seg_rd}), '0);
      if (i == 1) chk("starve_tvalid_drop", wv_t'(m_tvalid), '0);
    end
    step(0, 0, 0, 1);
    chk("starve_snd_rd", wv_t'({fst_rd, snd_rd, seg_rd}), wv_t'(3'b010));
    step(0, 0, 0, 1);
    chk("starve_b_valid", wv_t'(m_tvalid), wv_t'(1));
    step(0, 0, 0, 1);

    // Back-to-back: 1-seg then 2-seg, all preloaded.
    base = acc_pkts;
    add_pkt(1);
    add_pkt(2);
    vec = '0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      vec[4-i] = m_tvalid;
    end
    chk("b2b_tvalid_run", wv_t'(vec[4:0]), wv_t'(5'b01110));
    chk("b2b_pkt_cnt", wv_t'(pkt_cnt), wv_t'(base + 2));

    // Asynchronous reset in the middle of FLUSH_SEG.
    add_pkt(5);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("mid_seg_rd", wv_t'({fst_rd, snd_rd, seg_rd}), wv_t'(3'b001));
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", wv_t'(m_tvalid), '0);
    chk("arst_pkt_cnt", wv_t'(pkt_cnt), '0);
    chk("arst_rd_en", wv_t'({fst_rd, snd_rd, seg_rd}), '0);
    model_reset();
    add_pkt(2);
    drive_heads();
    @(posedge clk);
    release_reset();
    chk("post_rst_fst_rd", wv_t'({fst_rd, snd_rd, seg_rd}), wv_t'(3'b100));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("post_rst_drained", wv_t'(expq.size()), '0);

    // Randomized traffic with random starvation and backpressure.
    for (int p = 0; p < 40; p++) add_pkt($urandom_range(6, 1));
    for (int c = 0; c < 5000 && expq.size() != 0; c++)
      step($urandom_range(99) < 20, $urandom_range(99) < 20,
           $urandom_range(99) < 20, $urandom_range(99) < 70);
    chk("rand_drain_timeout", wv_t'(expq.size()), '0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rand_final_pkt_cnt", wv_t'(pkt_cnt), wv_t'(acc_pkts));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
